bemf_scheduler: RTL and testbench

BEMF_SCHEDULER -- requirements
Module: bemf_scheduler

---
 rtl/bemf_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_bemf_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bemf_scheduler.sv
// Back-EMF measurement scheduler: round-robin picks one axis per slot, coasts it,
// requests an ADC conversion, captures the sample and restores drive.
// Optional build macro BEMF_SCHED_TIMEOUT_EN: a stalled conversion is forced to
// complete with an all-ones sample after 255 cycles without an acknowledge.
module bemf_scheduler #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned SETTLE_W = 12,
  parameter int unsigned ADC_W    = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [3:0]          AxisEn,
  input  logic [PERIOD_W-1:0] Period,
  input  logic [SETTLE_W-1:0] Settle,
  output logic [3:0]          Active,
  output logic [3:0]          Measure,
  output logic                AdcReq,
  output logic [1:0]          AdcChan,
  input  logic                AdcAck,
  input  logic [ADC_W-1:0]    AdcData,
  output logic                ResultValid,
  output logic [1:0]          ResultAxis,
  output logic [ADC_W-1:0]    ResultData,
  output logic                IntStatus,
  input  logic                IntReset
);

  localparam int unsigned AXIS_W = 2;
  localparam int unsigned TO_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_COAST,
    S_CONVERT,
    S_RESTORE
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] gap_q, gap_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [AXIS_W-1:0]   axis_q, axis_d;
  logic [AXIS_W-1:0]   ptr_q, ptr_d;
  logic [3:0]          active_q, active_d;
  logic [3:0]          measure_q, measure_d;
  logic                adc_req_q, adc_req_d;
  logic [AXIS_W-1:0]   adc_chan_q, adc_chan_d;
  logic                res_valid_q, res_valid_d;
  logic [AXIS_W-1:0]   res_axis_q, res_axis_d;
  logic [ADC_W-1:0]    res_data_q, res_data_d;
  logic                int_q, int_d;

  logic [AXIS_W-1:0]   next_axis;
  logic [AXIS_W-1:0]   cand;
  logic                found;
  logic                adc_done;
  logic [ADC_W-1:0]    adc_val;
  logic                coasting;

  // Round-robin pick: first enabled axis after ptr, ptr itself checked last
  always_comb begin
    next_axis = ptr_q;
    cand      = ptr_q;
    found     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = AXIS_W'(ptr_q + AXIS_W'(i));
      if (!found && AxisEn[cand]) begin
        next_axis = cand;
        found     = 1'b1;
      end
    end
  end

`ifdef BEMF_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;

  // Conversion completes on acknowledge or when the stall counter saturates
  always_comb begin
    adc_done = AdcAck || (to_q == {TO_W{1'b1}});
    adc_val  = AdcAck ? AdcData : {ADC_W{1'b1}};
    to_d     = (state_q == S_CONVERT && state_d == S_CONVERT) ? TO_W'(to_q + TO_W'(1)) : '0;
  end

  // Stall counter register, cleared whenever CONVERT is left or entered
  always_ff @(posedge Clk) begin
    if (Reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  // Conversion completes only on acknowledge
  always_comb begin
    adc_done = AdcAck;
    adc_val  = AdcData;
  end
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    settle_d    = settle_q;
    axis_d      = axis_q;
    ptr_d       = ptr_q;
    res_valid_d = 1'b0;
    res_axis_d  = res_axis_q;
    res_data_d  = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (Enable && (AxisEn != 4'h0)) begin
          state_d = S_WAIT;
          gap_d   = Period;
        end
      end
      S_WAIT: begin
        if (!Enable || (AxisEn == 4'h0)) begin
          state_d = S_IDLE;
        end else if (gap_q == '0) begin
          state_d  = S_COAST;
          axis_d   = next_axis;
          settle_d = Settle;
        end else begin
          gap_d = PERIOD_W'(gap_q - PERIOD_W'(1));
        end
      end
      S_COAST: begin
        if (settle_q == '0) state_d = S_CONVERT;
        else                settle_d = SETTLE_W'(settle_q - SETTLE_W'(1));
      end
      S_CONVERT: begin
        if (adc_done) begin
          state_d     = S_RESTORE;
          res_data_d  = adc_val;
          res_axis_d  = axis_q;
          res_valid_d = 1'b1;
        end
      end
      S_RESTORE: begin
        ptr_d = axis_q;
        if (Enable && (AxisEn != 4'h0)) begin
          state_d = S_WAIT;
          gap_d   = Period;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    coasting   = (state_d == S_COAST) || (state_d == S_CONVERT);
    active_d   = coasting ? ~(4'b0001 << axis_d) : 4'hF;
    adc_req_d  = (state_d == S_CONVERT);
    measure_d  = adc_req_d ? (4'b0001 << axis_d) : 4'h0;
    adc_chan_d = adc_req_d ? axis_d : adc_chan_q;
    int_d      = res_valid_q ? 1'b1 : (IntReset ? 1'b0 : int_q);
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      settle_q    <= '0;
      axis_q      <= '0;
      ptr_q       <= AXIS_W'(3);
      active_q    <= 4'h0;
      measure_q   <= 4'h0;
      adc_req_q   <= 1'b0;
      adc_chan_q  <= '0;
      res_valid_q <= 1'b0;
      res_axis_q  <= '0;
      res_data_q  <= '0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      settle_q    <= settle_d;
      axis_q      <= axis_d;
      ptr_q       <= ptr_d;
      active_q    <= active_d;
      measure_q   <= measure_d;
      adc_req_q   <= adc_req_d;
      adc_chan_q  <= adc_chan_d;
      res_valid_q <= res_valid_d;
      res_axis_q  <= res_axis_d;
      res_data_q  <= res_data_d;
      int_q       <= int_d;
    end
  end

  assign Active      = active_q;
  assign Measure     = measure_q;
  assign AdcReq      = adc_req_q;
  assign AdcChan     = adc_chan_q;
  assign ResultValid = res_valid_q;
  assign ResultAxis  = res_axis_q;
  assign ResultData  = res_data_q;
  assign IntStatus   = int_q;

endmodule

// File: tb/tb_bemf_scheduler.sv
// Directed self-checking bench for bemf_scheduler.
module tb_bemf_scheduler;

  logic        Clk;
  logic        Reset;
  logic        Enable;
  logic [3:0]  AxisEn;
  logic [15:0] Period;
  logic [11:0] Settle;
  logic [3:0]  Active;
  logic [3:0]  Measure;
  logic        AdcReq;
  logic [1:0]  AdcChan;
  logic        AdcAck;
  logic [9:0]  AdcData;
  logic        ResultValid;
  logic [1:0]  ResultAxis;
  logic [9:0]  ResultData;
  logic        IntStatus;
  logic        IntReset;

  int n_tests = 0;
  int n_fail  = 0;
  int inv_err = 0;

  logic auto_ack  = 1'b0;
  logic force_ack = 1'b0;
  logic watch     = 1'b0;
  int   req_cnt   = 0;

  bemf_scheduler dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .AxisEn(AxisEn),
    .Period(Period), .Settle(Settle), .Active(Active), .Measure(Measure),
    .AdcReq(AdcReq), .AdcChan(AdcChan), .AdcAck(AdcAck), .AdcData(AdcData),
    .ResultValid(ResultValid), .ResultAxis(ResultAxis), .ResultData(ResultData),
    .IntStatus(IntStatus), .IntReset(IntReset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ADC model: sample value encodes the channel; ack two cycles after request
  always_comb AdcData = force_ack ? 10'h155 : {AdcChan, 8'h3C};

  initial AdcAck = 1'b0;
  always begin
    @(posedge Clk);
    #2;
    if (force_ack) begin
      AdcAck = 1'b1;
    end else if (AdcAck) begin
      AdcAck  = 1'b0;
      req_cnt = 0;
    end else if (auto_ack && AdcReq) begin
      req_cnt++;
      if (req_cnt >= 2) AdcAck = 1'b1;
    end else begin
      req_cnt = 0;
    end
  end

  // Structural properties watched every cycle outside reset
  logic r_rst;
  logic rv_prev = 1'b0;
  always begin
    @(posedge Clk);
    r_rst = Reset;
    #3;
    if (!r_rst) begin
      if ($countones(~Active) > 1) inv_err++;
      if ((Measure != 4'h0) && !AdcReq) inv_err++;
      if (watch && (!Active[1] || !Active[3])) inv_err++;
      if (ResultValid && rv_prev) inv_err++;
    end
    rv_prev = r_rst ? 1'b0 : ResultValid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [1:0] rq_axis [4];
  logic [9:0] rq_data [4];
  int got;
  int cnt;
  logic [1:0] exp_axis;

  initial begin
    Reset = 1'b1; Enable = 1'b0; AxisEn = 4'h0; Period = '0; Settle = '0; IntReset = 1'b0;
    for (int i = 0; i < 4; i++) begin rq_axis[i] = 2'h0; rq_data[i] = 10'h0; end
    tick(); tick(); tick();

    // reset values
    chk("rst_active",  32'(Active), 32'h0);
    chk("rst_measure", 32'(Measure), 32'h0);
    chk("rst_adcreq",  32'(AdcReq), 32'h0);
    chk("rst_adcchan", 32'(AdcChan), 32'h0);
    chk("rst_rvalid",  32'(ResultValid), 32'h0);
    chk("rst_raxis",   32'(ResultAxis), 32'h0);
    chk("rst_rdata",   32'(ResultData), 32'h0);
    chk("rst_int",     32'(IntStatus), 32'h0);
    Reset = 1'b0;
    tick();
    chk("rel_active", 32'(Active), 32'hF);
    tick();
    chk("rel_active2", 32'(Active), 32'hF);

    // round-robin over axes 0 and 2
    auto_ack = 1'b1; watch = 1'b1;
    AxisEn = 4'b0101; Period = 16'd4; Settle = 12'd3; Enable = 1'b1;
    got = 0;
    for (int k = 0; k < 400 && got < 4; k++) begin
      tick();
      if (ResultValid) begin
        rq_axis[got] = ResultAxis;
        rq_data[got] = ResultData;
        got++;
      end
    end
    Enable = 1'b0;
    watch  = 1'b0;
    chk("rr_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_axis = 2'((i % 2) * 2);
      chk("rr_axis", 32'(rq_axis[i]), 32'(exp_axis));
      chk("rr_data", 32'(rq_data[i]), 32'({exp_axis, 8'h3C}));
    end
    tick(); tick(); tick();
    chk("rr_idle_active", 32'(Active), 32'hF);

    // minimal timing on axis 3, plus interrupt set/clear priority
    AxisEn = 4'b1000; Period = 16'd0; Settle = 12'd0; Enable = 1'b1; IntReset = 1'b1;
    tick();                                   // c1 WAIT
    IntReset = 1'b0;
    chk("p0_c1_int",    32'(IntStatus), 32'h0);
    chk("p0_c1_active", 32'(Active), 32'hF);
    chk("p0_c1_req",    32'(AdcReq), 32'h0);
    tick();                                   // c2 COAST
    chk("p0_c2_active", 32'(Active), 32'h7);
    chk("p0_c2_req",    32'(AdcReq), 32'h0);
    tick();                                   // c3 CONVERT
    chk("p0_c3_req",    32'(AdcReq), 32'h1);
    chk("p0_c3_meas",   32'(Measure), 32'h8);
    chk("p0_c3_chan",   32'(AdcChan), 32'h3);
    tick();                                   // c4 CONVERT, ack pending
    chk("p0_c4_req",    32'(AdcReq), 32'h1);
    tick();                                   // c5 RESTORE
    chk("p0_c5_rv",     32'(ResultValid), 32'h1);
    chk("p0_c5_raxis",  32'(ResultAxis), 32'h3);
    chk("p0_c5_rdata",  32'(ResultData), 32'h33C);
    chk("p0_c5_active", 32'(Active), 32'hF);
    chk("p0_c5_meas",   32'(Measure), 32'h0);
    chk("p0_c5_req",    32'(AdcReq), 32'h0);
    tick();                                   // c6 WAIT
    chk("p0_c6_rv",     32'(ResultValid), 32'h0);
    chk("p0_c6_int",    32'(IntStatus), 32'h1);
    tick();                                   // c7 COAST
    chk("p0_c7_active", 32'(Active), 32'h7);
    IntReset = 1'b1;
    tick();                                   // c8 CONVERT
    IntReset = 1'b0;
    chk("p0_c8_int",    32'(IntStatus), 32'h0);
    chk("p0_c8_req",    32'(AdcReq), 32'h1);
    tick();                                   // c9
    tick();                                   // c10 RESTORE
    chk("p0_c10_rv",    32'(ResultValid), 32'h1);
    chk("p0_c10_raxis", 32'(ResultAxis), 32'h3);
    IntReset = 1'b1;
    tick();                                   // c11 WAIT
    chk("p0_c11_rv",    32'(ResultValid), 32'h0);
    chk("int_set_wins", 32'(IntStatus), 32'h1);
    Enable = 1'b0;
    tick();                                   // c12 IDLE
    IntReset = 1'b0;
    chk("int_cleared",  32'(IntStatus), 32'h0);
    chk("p0_c12_active", 32'(Active), 32'hF);
    tick();

    // Enable dropped in the second COAST cycle on axis 1
    AxisEn = 4'b0010; Period = 16'd1; Settle = 12'd3; Enable = 1'b1;
    tick(); tick();                           // c1, c2 WAIT
    tick();                                   // c3 COAST
    chk("ab_c3_active", 32'(Active), 32'hD);
    tick();                                   // c4 COAST
    Enable = 1'b0;
    tick(); tick();                           // c5, c6 COAST
    chk("ab_c6_active", 32'(Active), 32'hD);
    tick();                                   // c7 CONVERT
    chk("ab_c7_req",    32'(AdcReq), 32'h1);
    chk("ab_c7_meas",   32'(Measure), 32'h2);
    tick();                                   // c8
    tick();                                   // c9 RESTORE
    chk("ab_c9_rv",     32'(ResultValid), 32'h1);
    chk("ab_c9_rdata",  32'(ResultData), 32'h13C);
    tick();                                   // c10 IDLE
    chk("ab_c10_rv",    32'(ResultValid), 32'h0);
    chk("ab_c10_active", 32'(Active), 32'hF);

    // acknowledge while idle has no effect
    force_ack = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ResultValid || AdcReq) cnt++;
      if (k == 4) force_ack = 1'b0;
    end
    chk("idle_ack_ignored", 32'(cnt), 32'd0);
    chk("idle_ack_data",    32'(ResultData), 32'h13C);

    // reset in the middle of a conversion
    auto_ack = 1'b0;
    AxisEn = 4'b0001; Period = 16'd0; Settle = 12'd0; Enable = 1'b1;
    tick(); tick(); tick();                   // c3 CONVERT
    chk("mr_req",  32'(AdcReq), 32'h1);
    chk("mr_chan", 32'(AdcChan), 32'h0);
    chk("mr_meas", 32'(Measure), 32'h1);
    tick();
    Reset = 1'b1;
    tick();
    chk("mr_rst_req",    32'(AdcReq), 32'h0);
    chk("mr_rst_active", 32'(Active), 32'h0);
    chk("mr_rst_meas",   32'(Measure), 32'h0);
    chk("mr_rst_rv",     32'(ResultValid), 32'h0);
    chk("mr_rst_rdata",  32'(ResultData), 32'h0);
    chk("mr_rst_raxis",  32'(ResultAxis), 32'h0);
    Reset = 1'b0; Enable = 1'b0;
    tick();
    chk("mr_rel_active", 32'(Active), 32'hF);
    chk("mr_rel_rv",     32'(ResultValid), 32'h0);

    // stalled conversion on axis 2
    AxisEn = 4'b0100; Enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20 && !AdcReq; k++) tick();
    chk("st_req", 32'(AdcReq), 32'h1);
    chk("st_chan", 32'(AdcChan), 32'h2);
`ifdef BEMF_SCHED_TIMEOUT_EN
    for (int k = 0; k < 400 && !ResultValid; k++) begin
      tick();
      cnt++;
    end
    chk("to_latency", 32'(cnt), 32'd256);
    chk("to_data",    32'(ResultData), 32'h3FF);
    chk("to_axis",    32'(ResultAxis), 32'h2);
`else
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (ResultValid) cnt++;
    end
    chk("nto_req_held", 32'(AdcReq), 32'h1);
    chk("nto_no_result", 32'(cnt), 32'd0);
`endif
    Reset = 1'b1; Enable = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();

    chk("invariants", 32'(inv_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
